shim_ad5676_dac_spi_tx: RTL and testbench
=========================================

SHIM_AD5676_DAC_SPI_TX -- requirements
Module: shim_ad5676_dac_spi_tx

Interface
REQ-001 SHALL have parameter CMD_BITS, default 24, giving the SPI command length in bits.
REQ-002 SHALL have port clk, input, 1 bit: the sole clock, running at 2x the SPI clock frequency.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port timing_valid, input, 1 bit: the upstream timing calculator reports done.
REQ-005 SHALL have port n_cs_high_time, input, 5 bits: required n_cs high time, in SPI cycles, minus 1.
REQ-006 SHALL have port cmd_data, input, CMD_BITS bits: command word, MSB first.
REQ-007 SHALL have port cmd_valid, input, 1 bit, and port cmd_ready, output, 1 bit: command handshake.
REQ-008 SHALL have port dac_n_cs, output, 1 bit: DAC chip select, active-low.
REQ-009 SHALL have port dac_sclk, output, 1 bit: SPI clock, idle high.
REQ-010 SHALL have port dac_sdi, output, 1 bit: serial data to the DAC.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement the states IDLE, SHIFT and CS_HIGH.
REQ-013 SHALL hold cmd_ready = timing_valid only in IDLE, and low in every other state.
REQ-014 SHALL accept a command on a clk edge with cmd_valid and cmd_ready both high, at edge T; on that edge it latches cmd_data and n_cs_high_time and enters SHIFT.
REQ-015 SHALL, from T+1: drive dac_n_cs=0, dac_sclk=1 and dac_sdi=cmd_data[CMD_BITS-1].
REQ-016 SHALL, in SHIFT: toggle dac_sclk every clk; the DAC samples on the falling edge; dac_sdi advances to the next bit on each rising edge.
REQ-017 SHALL hold dac_n_cs low for exactly 2*CMD_BITS clk cycles (T+1..T+48 for 24 bits), producing exactly CMD_BITS falling edges of dac_sclk.
REQ-018 SHALL, at T+2*CMD_BITS+1: set dac_n_cs=1, dac_sclk=1 and dac_sdi=0, then enter CS_HIGH.
REQ-019 SHALL, in CS_HIGH: count 2*(N+1) clk cycles, where N is the latched n_cs_high_time, then return to IDLE.
REQ-020 SHALL, with cmd_valid held high, give a dac_n_cs high time between frames of exactly 2*(N+1) clk cycles; it is never shorter.
REQ-021 SHALL keep the latched N and cmd_data stable for the whole frame; changes on n_cs_high_time, cmd_data or timing_valid mid-frame do not affect the current frame.
REQ-022 SHALL keep cmd_ready low while timing_valid is low; cmd_valid is then ignored and no frame starts.
REQ-023 SHALL treat N=0 as legal, giving 2 clk cycles of high time; N=31 gives 64 clk cycles.
REQ-024 SHALL drive dac_sdi = 0 whenever dac_n_cs = 1.
REQ-025 SHALL drive all outputs from registers, with no combinational path from inputs to dac_* outputs.

Reset
REQ-026 SHALL, on resetn low: asynchronously set state=IDLE, dac_n_cs=1, dac_sclk=1, dac_sdi=0, cmd_ready=0, busy=0, and clear the latched data and counters.
REQ-027 SHALL, on reset mid-frame: abort the frame immediately, raise n_cs without waiting for the high-time count, and discard the partial command.
REQ-028 SHALL evaluate cmd_ready from timing_valid on the first clk edge after resetn deasserts.

Configuration
REQ-029 SHALL gate readback on the macro SHIM_AD5676_DAC_SPI_TX_READBACK_EN.
REQ-030 SHALL, when the macro is defined, add ports dac_sdo (input, 1 bit), rd_data (output, CMD_BITS bits) and rd_valid (output, 1 bit).
REQ-031 SHALL, when the macro is defined: sample dac_sdo on each clk edge where dac_sclk goes 0 to 1 during SHIFT, shifting it in MSB first.
REQ-032 SHALL, when the macro is defined: update rd_data and pulse rd_valid for exactly one cycle coincident with dac_n_cs rising; both reset to 0.
REQ-033 SHALL, when the macro is not defined, omit these ports and the capture logic entirely.

Verification
REQ-034 SHALL cover: timing_valid=1, N=3, cmd 0x3A5F0C at edge T -> n_cs low T+1..T+48, 24 sclk falls, sdi bits match 0x3A5F0C MSB first.
REQ-035 SHALL cover: cmd_valid held high with two commands, N=3 -> n_cs high exactly 8 clk cycles between frames.
REQ-036 SHALL cover: timing_valid=0 with cmd_valid=1 for 100 cycles -> cmd_ready=0, n_cs stays 1; raising timing_valid -> accept next cycle.
REQ-037 SHALL cover: N changed from 31 to 3 mid-frame -> high time after that frame is 64 clk cycles; the next frame uses 3.
REQ-038 SHALL cover: resetn pulsed low at clk 20 of a frame -> n_cs=1, sclk=1, sdi=0 immediately, busy=0, no further sclk edges.
REQ-039 SHALL cover, with the macro defined: dac_sdo driven with 0xC0FFEE MSB first -> rd_data=0xC0FFEE and rd_valid a 1-cycle pulse at n_cs rising.

Source files
------------

// File: rtl/shim_ad5676_dac_spi_tx.sv
// shim_ad5676_dac_spi_tx: AD5676 SPI command transmitter, clk runs at 2x sclk, MSB first, n_cs high-time guard.
// Define SHIM_AD5676_DAC_SPI_TX_READBACK_EN to add dac_sdo capture (rd_data/rd_valid).
module shim_ad5676_dac_spi_tx #(
   parameter int CMD_BITS = 24
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                timing_valid,
   input  logic [4:0]          n_cs_high_time,
   input  logic [CMD_BITS-1:0] cmd_data,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   output logic                dac_n_cs,
   output logic                dac_sclk,
   output logic                dac_sdi,
   output logic                busy
`ifdef SHIM_AD5676_DAC_SPI_TX_READBACK_EN
   ,
   input  logic                dac_sdo,
   output logic [CMD_BITS-1:0] rd_data,
   output logic                rd_valid
`endif
);
   localparam int CW = $clog2(2 * CMD_BITS + 64);
   localparam logic [CW-1:0] LAST = CW'(2 * CMD_BITS - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, CS_HIGH} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0] n_q, n_d;
   logic [CMD_BITS-1:0] shreg_q, shreg_d;
   logic n_cs_q, n_cs_d, sclk_q, sclk_d, sdi_q, sdi_d, ready_q, ready_d, busy_q, busy_d;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      shreg_d = shreg_q;
      n_cs_d  = n_cs_q;
      sclk_d  = sclk_q;
      sdi_d   = sdi_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d = SHIFT;
               cnt_d   = '0;
               n_d     = n_cs_high_time;
               shreg_d = cmd_data;
               n_cs_d  = 1'b0;
               sclk_d  = 1'b1;
               sdi_d   = cmd_data[CMD_BITS-1];
            end
         end
         SHIFT: begin
            // data advances only on the sclk rising edge so it is stable at the DAC's falling-edge sample
            sclk_d  = ~sclk_q;
            cnt_d   = cnt_q + 1'b1;
            shreg_d = sclk_q ? shreg_q : shreg_q << 1;
            sdi_d   = shreg_d[CMD_BITS-1];
            if (cnt_q == LAST) begin
               state_d = CS_HIGH;
               cnt_d   = '0;
               shreg_d = '0;
               n_cs_d  = 1'b1;
               sclk_d  = 1'b1;
               sdi_d   = 1'b0;
            end
         end
         CS_HIGH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'({n_q, 1'b0})) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE) && timing_valid;
      busy_d  = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         n_q     <= '0;
         shreg_q <= '0;
         n_cs_q  <= 1'b1;
         sclk_q  <= 1'b1;
         sdi_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         shreg_q <= shreg_d;
         n_cs_q  <= n_cs_d;
         sclk_q  <= sclk_d;
         sdi_q   <= sdi_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end
   assign cmd_ready = ready_q;
   assign dac_n_cs  = n_cs_q;
   assign dac_sclk  = sclk_q;
   assign dac_sdi   = sdi_q;
   assign busy      = busy_q;
`ifdef SHIM_AD5676_DAC_SPI_TX_READBACK_EN
   logic [CMD_BITS-2:0] cap_q;
   logic [CMD_BITS-1:0] rd_data_q;
   logic rd_valid_q;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cap_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         if (state_q == SHIFT && !sclk_q) cap_q <= {cap_q[CMD_BITS-3:0], dac_sdo};
         // last rising edge of the frame coincides with n_cs going high
         if (state_q == SHIFT && cnt_q == LAST) begin
            rd_data_q  <= {cap_q, dac_sdo};
            rd_valid_q <= 1'b1;
         end
      end
   end
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_shim_ad5676_dac_spi_tx.sv
// tb_shim_ad5676_dac_spi_tx: table-driven frame checks plus directed corner sequences.
module tb_shim_ad5676_dac_spi_tx;
   logic clk = 1'b0;
   logic resetn, timing_valid, cmd_valid;
   logic [4:0] n_cs_high_time;
   logic [23:0] cmd_data;
   logic cmd_ready, dac_n_cs, dac_sclk, dac_sdi, busy;
`ifdef SHIM_AD5676_DAC_SPI_TX_READBACK_EN
   logic dac_sdo = 1'b0;
   logic [23:0] rd_data;
   logic rd_valid;
   logic [23:0] sdo_word = 24'h0;
`endif
   int n_cmp = 0;
   int n_err = 0;
   int idle_viol = 0;

   shim_ad5676_dac_spi_tx #(.CMD_BITS(24)) dut (
      .clk(clk), .resetn(resetn), .timing_valid(timing_valid),
      .n_cs_high_time(n_cs_high_time), .cmd_data(cmd_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .dac_n_cs(dac_n_cs), .dac_sclk(dac_sclk), .dac_sdi(dac_sdi), .busy(busy)
`ifdef SHIM_AD5676_DAC_SPI_TX_READBACK_EN
      , .dac_sdo(dac_sdo), .rd_data(rd_data), .rd_valid(rd_valid)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] cmd;
      logic [4:0]  n;
      int          exp_low;
      int          exp_falls;
      int          exp_high;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // counts n_cs-high samples until the next frame starts (bounded)
   task automatic wait_start(output int hi);
      hi = 0;
      while (dac_n_cs && hi < 300) begin
         if (dac_sdi || !dac_sclk) idle_viol++;
         hi++;
         @(negedge clk);
      end
   endtask

   // called on the first sample with n_cs low; returns on the first sample with n_cs high
   task automatic measure_frame(output int low, output int falls, output int viol, output logic [23:0] word);
      logic prev;
      low = 0; falls = 0; viol = 0; word = '0; prev = 1'b1;
      while (!dac_n_cs && low < 200) begin
         low++;
         if (!busy || cmd_ready) viol++;
`ifdef SHIM_AD5676_DAC_SPI_TX_READBACK_EN
         if (rd_valid) viol++;
`endif
         if (prev && !dac_sclk) begin
            word = {word[22:0], dac_sdi};
`ifdef SHIM_AD5676_DAC_SPI_TX_READBACK_EN
            if (falls < 24) dac_sdo = sdo_word[23 - falls];
`endif
            falls++;
         end
         prev = dac_sclk;
         @(negedge clk);
      end
   endtask

   initial begin
      vec_t vec[5];
      int hi, low, falls, viol, bad;
      logic [23:0] word;
      vec[0] = '{24'h3A5F0C, 5'd3,  48, 24, 8};
      vec[1] = '{24'hFFFFFF, 5'd0,  48, 24, 2};
      vec[2] = '{24'h000001, 5'd31, 48, 24, 64};
      vec[3] = '{24'h800000, 5'd3,  48, 24, 8};
      vec[4] = '{24'hA5A5A5, 5'd1,  48, 24, 4};
      resetn = 1'b0; timing_valid = 1'b0; cmd_valid = 1'b0;
      n_cs_high_time = 5'd0; cmd_data = 24'h0;
      repeat (3) @(negedge clk);
      check("reset_state", {dac_n_cs, dac_sclk, dac_sdi, cmd_ready, busy}, 5'b11000);
      timing_valid = 1'b1;
      resetn = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {cmd_ready, busy}, 2'b10);

      // back-to-back table frames; next vector is presented mid-frame
      cmd_data = vec[0].cmd; n_cs_high_time = vec[0].n; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_start(hi);
         if (i > 0) check("high_time", hi, vec[i-1].exp_high);
         else check("first_start", dac_n_cs, 1'b0);
         if (i < 4) begin
            cmd_data = vec[i+1].cmd; n_cs_high_time = vec[i+1].n;
         end else cmd_valid = 1'b0;
         measure_frame(low, falls, viol, word);
         check("low_cycles", low, vec[i].exp_low);
         check("sclk_falls", falls, vec[i].exp_falls);
         check("sdi_word", word, vec[i].cmd);
         check("frame_flags", viol, 0);
      end
      repeat (80) @(negedge clk);
      check("idle_after_table", {dac_n_cs, busy}, 2'b10);

      // timing_valid low blocks all commands
      timing_valid = 1'b0;
      @(negedge clk);
      cmd_data = 24'h5A5A5A; n_cs_high_time = 5'd3; cmd_valid = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (cmd_ready || !dac_n_cs) bad++;
         @(negedge clk);
      end
      check("tv_low_blocked", bad, 0);
      timing_valid = 1'b1;
      @(negedge clk);
      check("tv_rise_ready", {dac_n_cs, cmd_ready}, 2'b11);
      @(negedge clk);
      check("tv_rise_accept", dac_n_cs, 1'b0);
      cmd_valid = 1'b0;
      measure_frame(low, falls, viol, word);
      check("tv_frame_word", word, 24'h5A5A5A);
      repeat (20) @(negedge clk);

      // N changed 31 -> 3 during a frame
      cmd_data = 24'h123456; n_cs_high_time = 5'd31; cmd_valid = 1'b1;
      wait_start(hi);
      n_cs_high_time = 5'd3;
      measure_frame(low, falls, viol, word);
      wait_start(hi);
      check("n31_high", hi, 64);
      measure_frame(low, falls, viol, word);
      wait_start(hi);
      check("n3_high", hi, 8);
      cmd_valid = 1'b0;
      measure_frame(low, falls, viol, word);
      check("n3_word", word, 24'h123456);
      repeat (20) @(negedge clk);

      // reset mid-frame
      cmd_data = 24'hFFFFFF; n_cs_high_time = 5'd3; cmd_valid = 1'b1;
      wait_start(hi);
      cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("abort_outputs", {dac_n_cs, dac_sclk, dac_sdi, busy, cmd_ready}, 5'b11000);
      bad = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (c == 5) resetn = 1'b1;
         if (!dac_n_cs || !dac_sclk || dac_sdi || busy) bad++;
      end
      check("abort_quiet", bad, 0);

`ifdef SHIM_AD5676_DAC_SPI_TX_READBACK_EN
      sdo_word = 24'hC0FFEE;
      cmd_data = 24'h0F0F0F; cmd_valid = 1'b1;
      wait_start(hi);
      cmd_valid = 1'b0;
      measure_frame(low, falls, viol, word);
      check("rd_valid_pulse", rd_valid, 1'b1);
      check("rd_data", rd_data, 24'hC0FFEE);
      check("rb_frame_flags", viol, 0);
      @(negedge clk);
      check("rd_valid_end", rd_valid, 1'b0);
`endif
      check("idle_sdi_sclk", idle_viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
